stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clk cycles per 0.1 s tick (100 MHz clk); legal range 2 and up.
REQ-002 Parameter DB_CYCLES, default 1_000_000, consecutive stable samples required to accept a button level change; legal range 2 and up.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pp  input  1  raw asynchronous play/pause button, active-high.
REQ-006 lap  input  1  raw asynchronous lap button, active-high.
REQ-007 clr  input  1  raw asynchronous clear button, active-high.
REQ-008 tick  output  1  one-cycle pulse, counter-chain advance enable (0.1 s).
REQ-009 clear  output  1  one-cycle pulse, counter-chain synchronous clear.
REQ-010 latch  output  1  one-cycle pulse, capture the current count into the display lap register.
REQ-011 hold  output  1  level; 1 means the display shows the latched lap value, not the live count.
REQ-012 running  output  1  level; 1 in RUN or LAP.
REQ-013 state  output  2  current FSM state encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3.

Function
REQ-014 Each button SHALL pass through a 2-FF synchronizer and then a debouncer.
  - Debouncer holds a stable level; counter increments while the synced sample differs from stable and clears when they match.
  - Stable toggles when the counter reaches DB_CYCLES-1 on a differing sample, and the counter clears.
REQ-015 Each debouncer SHALL emit a one-cycle press event in the cycle after its stable level goes 0->1; release emits nothing.
REQ-016 FSM transitions SHALL occur on the edge where the event is high; the new state is visible the following cycle.
  - IDLE: pp -> RUN.
  - RUN: pp -> PAUSE; lap -> LAP.
  - LAP: lap -> RUN; pp -> PAUSE.
  - PAUSE: pp -> RUN; clr -> IDLE.
  - All other events are ignored in the current state.
REQ-017 Simultaneous events SHALL be resolved by priority clr > pp > lap; at most one transition per cycle, lower-priority events dropped.
REQ-018 clr in IDLE SHALL stay in IDLE and still produce a clear pulse; clr in RUN or LAP SHALL be ignored.
REQ-019 clear SHALL be a registered pulse asserted in the same cycle the new state (IDLE) first appears.
REQ-020 latch SHALL be a registered pulse asserted in the same cycle LAP first appears; it is not asserted on exit from LAP.
REQ-021 Outputs SHALL decode from the state register: hold=1 only in LAP; running=1 in RUN or LAP.
REQ-022 Prescaler SHALL count 0..TICK_DIV-1 only while running=1, wrap to 0, and assert tick (registered) for one cycle per wrap.
  - First tick occurs TICK_DIV cycles after running rises.
REQ-023 Prescaler SHALL freeze its value in PAUSE so that a resume completes the partial interval.
  - Prescaler resets to 0 on a clear pulse and in IDLE.
REQ-024 tick SHALL never assert while running=0, including the cycle a pp event leaves RUN/LAP (the transition takes precedence over the wrap).
REQ-025 The LAP<->RUN transition SHALL NOT disturb the prescaler or drop or duplicate a tick.

Reset
REQ-026 While reset=1 on an edge, the block SHALL load:
  - state=IDLE, prescaler=0, synchronizers=0, debounce counters=0, stable levels=0;
  - tick=clear=latch=0, hold=0, running=0.
REQ-027 Reset SHALL override all events in the same cycle.
  - A button held high through reset release is seen as a new press after DB_CYCLES+2 cycles; this is intentional.

Structure
REQ-028 Package stopwatch_pkg SHALL hold:
  - the state enum (IDLE, RUN, PAUSE, LAP with the REQ-013 encodings);
  - default constants TICK_DIV_DEF and DB_CYCLES_DEF.
REQ-029 Synchronizer, debounce and edge detection SHALL be one sub-module btn_debounce (param DB_CYCLES), instantiated three times.

Verification (TICK_DIV=5, DB_CYCLES=4)
REQ-030 Reset, then 20 idle cycles -> state=0, tick/clear/latch/hold/running all 0 throughout.
REQ-031 pp high 3 cycles, then low -> no event, state stays IDLE.
  - pp high 10 cycles -> exactly one event, RUN, running=1.
  - Ticks follow every 5 cycles, the first one 5 cycles after running rises.
REQ-032 RUN for 12 cycles, pp press -> PAUSE, no ticks while paused.
  - pp press again -> first tick after the remaining 3 cycles of the partial interval, then every 5.
REQ-033 In RUN, lap press -> latch pulse once, hold=1, ticks continue every 5 cycles.
  - Second lap press -> hold=0 with no tick gap or extra tick.
REQ-034 clr and pp debounced in the same cycle while in PAUSE -> IDLE, clear pulse, prescaler=0, pp dropped.
  - clr in RUN -> ignored.
REQ-035 Assert reset mid-RUN with prescaler=3 -> next cycle state=IDLE, outputs 0.
  - After release, the first tick comes 5 cycles after the next start.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control slice.
// State encodings are visible on the state output, so they are fixed here.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int TICK_DIV_DEF  = 10_000_000;
    localparam int DB_CYCLES_DEF = 1_000_000;

    function automatic logic is_running(input state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchronizer -> counter debouncer -> one-cycle press event.
// The press event appears the cycle after the stable level rises; release is silent.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // NOTE: every register here uses <= so all flops sample the pre-edge values;
    // blocking writes would collapse the synchronizer into a single stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons drive a 4-state FSM and a 0.1 s prescaler
// that emits tick/clear/latch pulses for an external counter chain and display.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pp,
    input  logic       lap,
    input  logic       clr,
    output logic       tick,
    output logic       clear,
    output logic       latch,
    output logic       hold,
    output logic       running,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic ev_pp;
    logic ev_lap;
    logic ev_clr;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pp  (.clk(clk), .reset(reset), .btn(pp),  .press(ev_pp));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (.clk(clk), .reset(reset), .btn(lap), .press(ev_lap));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (.clk(clk), .reset(reset), .btn(clr), .press(ev_clr));

    state_t        st_q;
    state_t        st_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_d;
    logic          clear_d;
    logic          latch_d;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        st_d    = st_q;
        clear_d = 1'b0;
        latch_d = 1'b0;
        // Only events that are legal in the current state compete for priority.
        case (st_q)
            IDLE: begin
                if (ev_clr)     clear_d = 1'b1;
                else if (ev_pp) st_d    = RUN;
            end
            RUN: begin
                if (ev_pp) begin
                    st_d = PAUSE;
                end else if (ev_lap) begin
                    st_d    = LAP;
                    latch_d = 1'b1;
                end
            end
            LAP: begin
                if (ev_pp)       st_d = PAUSE;
                else if (ev_lap) st_d = RUN;
            end
            PAUSE: begin
                if (ev_clr) begin
                    st_d    = IDLE;
                    clear_d = 1'b1;
                end else if (ev_pp) begin
                    st_d = RUN;
                end
            end
            default: st_d = IDLE;
        endcase

        // A wrap on the edge that leaves RUN/LAP still restarts the interval,
        // but its tick is suppressed because the counter chain is stopping.
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (st_d == IDLE) begin
            presc_d = '0;
        end else if (is_running(st_q)) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = is_running(st_d);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= IDLE;
            presc_q <= '0;
            tick    <= 1'b0;
            clear   <= 1'b0;
            latch   <= 1'b0;
        end else begin
            st_q    <= st_d;
            presc_q <= presc_d;
            tick    <= tick_d;
            clear   <= clear_d;
            latch   <= latch_d;
        end
    end

    assign running = is_running(st_q);
    assign hold    = (st_q == LAP);
    assign state   = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=5, DB_CYCLES=4): directed
// scenarios with literal expectations, then random button activity against a model.
module tb_stopwatch_ctrl;

    localparam int TD = 5;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       pp_i;
    logic       lap_i;
    logic       clr_i;
    logic       tick;
    logic       clear;
    logic       latch;
    logic       hold;
    logic       running;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .pp(pp_i), .lap(lap_i), .clr(clr_i),
        .tick(tick), .clear(clear), .latch(latch), .hold(hold),
        .running(running), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. Buttons: 0=pp 1=lap 2=clr. A button's synchronized view is
    // its raw level two edges ago; its stable level flips after DB consecutive
    // disagreeing samples; a rising flip shows up as an event one cycle later.
    // m_rc counts running cycles since the last IDLE; a tick follows every TD-th.
    int m_st = 0;
    int m_rc = 0;
    bit m_tick = 0, m_clear = 0, m_latch = 0;
    bit rh1[3], rh2[3], stab[3], evd[3], ev[3];
    int run_len[3];

    always @(posedge clk) begin : model
        bit raw[3];
        int nst;
        bit cl, la, wasrun, nrun;
        raw[0] = pp_i;
        raw[1] = lap_i;
        raw[2] = clr_i;
        if (reset) begin
            m_st = 0; m_rc = 0; m_tick = 0; m_clear = 0; m_latch = 0;
            for (int b = 0; b < 3; b++) begin
                rh1[b] = 0; rh2[b] = 0; stab[b] = 0; evd[b] = 0; ev[b] = 0; run_len[b] = 0;
            end
        end else begin
            nst = m_st; cl = 0; la = 0;
            if (ev[2] && (m_st == 0 || m_st == 2)) begin
                nst = 0; cl = 1;
            end else if (ev[0]) begin
                nst = (m_st == 0 || m_st == 2) ? 1 : 2;
            end else if (ev[1] && m_st == 1) begin
                nst = 3; la = 1;
            end else if (ev[1] && m_st == 3) begin
                nst = 1;
            end
            wasrun = (m_st == 1 || m_st == 3);
            nrun   = (nst == 1 || nst == 3);
            m_tick = 0;
            if (wasrun) begin
                m_rc++;
                m_tick = ((m_rc % TD) == 0) && nrun;
            end
            if (nst == 0) m_rc = 0;
            m_st = nst; m_clear = cl; m_latch = la;
            for (int b = 0; b < 3; b++) begin
                ev[b]  = evd[b];
                evd[b] = 0;
                if (rh2[b] != stab[b]) begin
                    run_len[b]++;
                    if (run_len[b] == DB) begin
                        stab[b]    = !stab[b];
                        run_len[b] = 0;
                        evd[b]     = stab[b];
                    end
                end else begin
                    run_len[b] = 0;
                end
                rh2[b] = rh1[b];
                rh1[b] = raw[b];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state",   state,   m_st);
            check("tick",    tick,    m_tick);
            check("clear",   clear,   m_clear);
            check("latch",   latch,   m_latch);
            check("hold",    hold,    m_st == 3);
            check("running", running, m_st == 1 || m_st == 3);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int budget, input string nm);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (state == tgt) found = 1;
        end
        check(nm, found, 1);
    endtask

    initial begin
        logic [7:0] acc;
        int tk;
        reset = 1'b1; pp_i = 1'b0; lap_i = 1'b0; clr_i = 1'b0;
        cyc(3);
        cmp_en = 1'b1;
        reset  = 1'b0;

        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc |= {tick, clear, latch, hold, running, 1'b0, state};
        end
        check("idle_quiet", acc, 0);

        pp_i = 1; cyc(3); pp_i = 0; cyc(15);
        check("short_press_ignored", state, 0);

        pp_i = 1;
        wait_state(1, 20, "start_run");
        cyc(2); pp_i = 0;
        cyc(2); check("no_tick_r4", tick, 0);
        cyc(1); check("first_tick_r5", tick, 1);
        check("running_in_run", running, 1);
        cyc(5); check("second_tick_r10", tick, 1);

        lap_i = 1; cyc(6); lap_i = 0;
        wait_state(3, 20, "enter_lap");
        check("latch_on_lap", latch, 1);
        check("hold_in_lap", hold, 1);
        cyc(1); check("latch_one_cycle", latch, 0);
        cyc(10);
        lap_i = 1; cyc(6); lap_i = 0;
        wait_state(1, 20, "lap_back_to_run");
        check("hold_cleared", hold, 0);
        check("no_latch_on_exit", latch, 0);
        cyc(10);

        pp_i = 1; cyc(6); pp_i = 0;
        wait_state(2, 20, "pause");
        tk = 0;
        repeat (20) begin
            @(negedge clk);
            tk += int'(tick);
        end
        check("no_tick_paused", tk, 0);

        pp_i = 1; clr_i = 1; cyc(6); pp_i = 0; clr_i = 0;
        wait_state(0, 20, "clr_to_idle");
        check("clear_pulse", clear, 1);
        cyc(1); check("clear_one_cycle", clear, 0);
        cyc(10);
        check("pp_dropped", state, 0);
        check("idle_not_running", running, 0);

        // 17 running cycles leave 2 of 5 counted, so resume ticks after 3.
        pp_i = 1;
        wait_state(1, 20, "restart_run");
        pp_i = 0; cyc(9);
        pp_i = 1; cyc(8);
        check("pause_after_17", state, 2);
        pp_i = 0; cyc(8);
        pp_i = 1; cyc(8);
        check("resume", state, 1);
        pp_i = 0;
        cyc(2); check("partial_no_tick", tick, 0);
        cyc(1); check("partial_interval_tick", tick, 1);
        cyc(5); check("tick_after_resume", tick, 1);

        clr_i = 1; cyc(6); clr_i = 0; cyc(7);
        check("clr_in_run_ignored", state, 1);
        reset = 1; cyc(1);
        check("reset_midrun_state", state, 0);
        check("reset_midrun_running", running, 0);
        check("reset_midrun_tick", tick, 0);
        cyc(1); reset = 0;

        cyc(5);
        pp_i = 1;
        wait_state(1, 20, "start_after_reset");
        pp_i = 0;
        cyc(4); check("no_tick_after_reset_r4", tick, 0);
        cyc(1); check("first_tick_after_reset", tick, 1);
        cyc(10);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                reset = 1;
                cyc($urandom_range(1, 2));
                reset = 0;
            end else begin
                pp_i  = ($urandom_range(0, 2) == 0);
                lap_i = ($urandom_range(0, 3) == 0);
                clr_i = ($urandom_range(0, 4) == 0);
                cyc($urandom_range(1, 12));
            end
        end
        pp_i = 0; lap_i = 0; clr_i = 0;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
